// File: rtl/fft_addr_gen.sv
// fft_addr_gen: radix-2 DIT FFT butterfly address/twiddle schedule generator.
// Walks every stage's N/2 butterflies, then idles GAP cycles so the pipeline drains.
module fft_addr_gen #(
    parameter int LOG2N = 5,
    parameter int GAP   = 9
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              start,
    input  logic                                              stall,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              valid,
    output logic [(($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1)-1:0] stage,
    output logic [LOG2N-1:0]                                  addr_a,
    output logic [LOG2N-1:0]                                  addr_b,
    output logic [LOG2N-2:0]                                  tw_addr,
    output logic                                              last
);
    localparam int JW = LOG2N - 1;
    localparam int SW = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1;
    localparam int DW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    s_q, s_d, stage_q, stage_d;
    logic [JW-1:0]    j_q, j_d, tw_q, tw_d, tw_c;
    logic [DW-1:0]    g_q, g_d;
    logic [LOG2N-1:0] a_q, a_d, b_q, b_d, jx, mask, a_c, b_c;
    logic             busy_q, busy_d, done_q, done_d, valid_q, valid_d, last_q, last_d;
    logic             end_stage, last_stage, gap_end;

    always_comb begin
        jx         = {1'b0, j_q};
        mask       = (LOG2N'(1) << s_q) - LOG2N'(1);
        a_c        = ((jx >> s_q) << (int'(s_q) + 1)) | (jx & mask);
        b_c        = a_c | (LOG2N'(1) << s_q);
        tw_c       = JW'((jx & mask) << (JW - int'(s_q)));
        end_stage  = &j_q;
        last_stage = (s_q == SW'(LOG2N - 1));
        gap_end    = (g_q == DW'(GAP - 1));
        state_d    = state_q;
        s_d        = s_q;
        j_d        = j_q;
        g_d        = g_q;
        busy_d     = (state_q != IDLE);
        done_d     = (state_q == DONE);
        valid_d    = 1'b0;
        last_d     = 1'b0;
        stage_d    = stage_q;
        a_d        = a_q;
        b_d        = b_q;
        tw_d       = tw_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                s_d     = '0;
                j_d     = '0;
            end
            RUN: begin
                // Triple tracks the frozen counters, so a stalled butterfly is reissued intact.
                stage_d = s_q;
                a_d     = a_c;
                b_d     = b_c;
                tw_d    = tw_c;
                if (!stall) begin
                    valid_d = 1'b1;
                    last_d  = end_stage;
                    j_d     = j_q + 1'b1;
                    if (end_stage) begin
                        if (GAP != 0) begin
                            state_d = DRAIN;
                            g_d     = '0;
                        end else if (last_stage) begin
                            state_d = DONE;
                        end else begin
                            s_d = s_q + 1'b1;
                        end
                    end
                end
            end
            DRAIN: if (!stall) begin
                if (gap_end) begin
                    state_d = last_stage ? DONE : RUN;
                    s_d     = last_stage ? s_q : s_q + 1'b1;
                end else begin
                    g_d = g_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            g_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            stage_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            g_q     <= g_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            stage_q <= stage_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tw_q    <= tw_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign valid   = valid_q;
    assign last    = last_q;
    assign stage   = stage_q;
    assign addr_a  = a_q;
    assign addr_b  = b_q;
    assign tw_addr = tw_q;
endmodule

// File: tb/tb_fft_addr_gen.sv
// tb_fft_addr_gen: random start/stall stimulus scored per cycle against a schedule-level model,
// plus directed reset, latency and GAP=0 scenarios.
module tb_fft_addr_gen;
    localparam int LOG2N = 3;
    localparam int GAP   = 2;
    localparam int N     = 1 << LOG2N;
    localparam int H     = N / 2;
    localparam int T     = LOG2N * (H + GAP);

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, start2 = 1'b0;
    logic       busy, done, valid, last, busy2, done2, valid2, last2;
    logic [1:0] stage, tw_addr;
    logic [2:0] addr_a, addr_b;
    logic       stage2, tw2;
    logic [1:0] a2, b2;

    int checks = 0, failures = 0;
    int ms = 0, w = 0;

    fft_addr_gen #(.LOG2N(LOG2N), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .busy(busy), .done(done),
        .valid(valid), .stage(stage), .addr_a(addr_a), .addr_b(addr_b), .tw_addr(tw_addr), .last(last)
    );

    fft_addr_gen #(.LOG2N(2), .GAP(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stall(1'b0), .busy(busy2), .done(done2),
        .valid(valid2), .stage(stage2), .addr_a(a2), .addr_b(b2), .tw_addr(tw2), .last(last2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Butterfly k of group g in stage st: pairs are half apart, twiddle stride shrinks per stage.
    task automatic check_triple(input int st, input int slot);
        int half, g, k, a;
        half = 1 << st;
        g    = slot / half;
        k    = slot % half;
        a    = g * 2 * half + k;
        check("addr_a", int'(addr_a), a);
        check("addr_b", int'(addr_b), a + half);
        check("tw_addr", int'(tw_addr), k * (N / (2 * half)));
        check("stage", int'(stage), st);
    endtask

    task automatic model(input logic st, input logic sl);
        int slot, stg;
        case (ms)
            0: begin
                check("busy", int'(busy), 0);
                check("done", int'(done), 0);
                check("valid", int'(valid), 0);
                check("last", int'(last), 0);
                if (st) begin ms = 1; w = 0; end
            end
            1: begin
                slot = w % (H + GAP);
                stg  = w / (H + GAP);
                check("busy", int'(busy), 1);
                check("done", int'(done), 0);
                if (slot < H) begin
                    check("valid", int'(valid), sl ? 0 : 1);
                    check("last", int'(last), (!sl && slot == H - 1) ? 1 : 0);
                    check_triple(stg, slot);
                end else begin
                    check("valid", int'(valid), 0);
                    check("last", int'(last), 0);
                end
                if (!sl) begin
                    w++;
                    if (w == T) ms = 2;
                end
            end
            default: begin
                check("busy", int'(busy), 1);
                check("done", int'(done), 1);
                check("valid", int'(valid), 0);
                check("last", int'(last), 0);
                ms = 0;
            end
        endcase
    endtask

    task automatic step(input logic st, input logic sl);
        @(negedge clk);
        start = st;
        stall = sl;
        @(posedge clk);
        #1;
        model(st, sl);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_last"}, int'(last), 0);
        check({tag, "_stage"}, int'(stage), 0);
        check({tag, "_a"}, int'(addr_a), 0);
        check({tag, "_b"}, int'(addr_b), 0);
        check({tag, "_tw"}, int'(tw_addr), 0);
    endtask

    initial begin
        int n, stalls;
        int ea[4] = '{0, 2, 0, 1};
        int eb[4] = '{1, 3, 2, 3};
        int et[4] = '{0, 0, 0, 1};
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom_range(0, 1)));
        // Unstalled run: done must land LOG2N*(N/2+GAP)+1 = 19 edges after acceptance.
        step(1'b1, 1'b0);
        n = 0;
        do begin step(1'b0, 1'b0); n++; end while (!done && n < 100);
        check("latency", n, T + 1);
        step(1'b0, 1'b0);
        // Stall 3 cycles on stage 1, j=1; done slips by exactly 3.
        step(1'b1, 1'b0);
        n = 0;
        stalls = 0;
        do begin
            if (ms == 1 && w == H + GAP + 1 && stalls < 3) begin
                stalls++;
                step(1'b0, 1'b1);
            end else begin
                step(1'b0, 1'b0);
            end
            n++;
        end while (!done && n < 100);
        check("stall_latency", n, T + 1 + 3);
        for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 25));
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
        while (ms != 0) step(1'b0, 1'b0);
        // Async reset while stage 2 drains, then a clean replay from the first butterfly.
        step(1'b1, 1'b0);
        n = 0;
        while (!(ms == 1 && w == 2 * (H + GAP) + H + 1) && n < 100) begin step(1'b0, 1'b0); n++; end
        check("reached_drain", w, 2 * (H + GAP) + H + 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        ms = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        n = 0;
        do begin step(1'b0, 1'b0); n++; end while (!done && n < 100);
        check("replay_latency", n, T + 1);
        // GAP=0, LOG2N=2: four back-to-back butterflies then done.
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            #1;
            if (e < 4) begin
                check("g0_valid", int'(valid2), 1);
                check("g0_a", int'(a2), ea[e]);
                check("g0_b", int'(b2), eb[e]);
                check("g0_tw", int'(tw2), et[e]);
                check("g0_last", int'(last2), e % 2);
                check("g0_done", int'(done2), 0);
            end else begin
                check("g0_valid_end", int'(valid2), 0);
                check("g0_done_end", int'(done2), 1);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 Parameter LOG2N, default 5, means log2 of the FFT size N; legal range is 2..10.
REQ-002 Parameter GAP, default 9, means the number of idle (drain) cycles inserted after each stage so that the butterfly pipeline empties before the next stage reads.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to run one full FFT schedule; sampled only in IDLE.
REQ-006 Port stall, input, 1 bit: while high, the schedule is frozen.
REQ-007 Port busy, output, 1 bit: high in every state except IDLE.
REQ-008 Port done, output, 1 bit: one-cycle pulse marking the end of the schedule.
REQ-009 Port valid, output, 1 bit: the current addr_a/addr_b/tw_addr triple is a real butterfly.
REQ-010 Port stage, output, max(1,clog2(LOG2N)) bits: current stage index, 0..LOG2N-1.
REQ-011 Port addr_a, output, LOG2N bits: data-memory index of the butterfly upper input.
REQ-012 Port addr_b, output, LOG2N bits: data-memory index of the butterfly lower input.
REQ-013 Port tw_addr, output, LOG2N-1 bits: twiddle ROM index (W_N^tw_addr; ROM word is 16-bit real : 16-bit imag Q1.15).
REQ-014 Port last, output, 1 bit: high with valid on the final butterfly of each stage.

Function
REQ-015 Schedule is radix-2 DIT over bit-reversed input; data words are 64-bit complex (32 real : 32 imag), consumed downstream by the butterfly unit.
REQ-016 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE -> RUN on clock edge with start=1; stage and butterfly counter j are cleared to 0 on that edge.
REQ-018 In RUN with stall=0: valid=1, and outputs are registered from the current (stage s, j):
- half = 2^s
- addr_a = ((j >> s) << (s+1)) + (j & (half-1))
- addr_b = addr_a + half
- tw_addr = (j & (half-1)) << (LOG2N-1-s)
REQ-019 In RUN, j increments by 1 per non-stalled cycle; at j = N/2-1 last=1, j wraps to 0, and the FSM moves to DRAIN.
REQ-020 DRAIN lasts exactly GAP non-stalled cycles with valid=0 and last=0.
- If s < LOG2N-1: s increments, then RUN.
- Otherwise: DONE.
- GAP=0 means RUN to RUN (or RUN to DONE) directly.
REQ-021 DONE lasts one cycle: done=1, busy=1, valid=0, then IDLE.
REQ-022 Stall behaviour:
- stall=1 in RUN or DRAIN freezes state, counters, addr_a/addr_b/tw_addr/stage and the drain counter.
- valid and last are forced to 0 while stalled.
- Stall has no effect in IDLE or DONE.
REQ-023 start while busy=1 is ignored; start and the DONE cycle coinciding does not restart, and a new start is accepted only in IDLE.
REQ-024 Without stall, the cycle count from start accepted to done high = LOG2N*(N/2+GAP)+1.
REQ-025 All outputs are registered; no combinational path from start or stall to any output.

Reset
REQ-026 rst_n=0 immediately forces IDLE and sets busy, done, valid, last, stage, addr_a, addr_b, tw_addr and all internal counters to 0, including mid-schedule.
REQ-027 After rst_n rises, the block stays in IDLE until start is sampled high on a later clock edge.

Verification
REQ-028 LOG2N=3, GAP=2, start pulse -> stage 0 valid pairs (a,b,tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0), last on the 4th, then 2 cycles with valid=0.
REQ-029 Same run -> stage 1 pairs = (0,2,0),(1,3,2),(4,6,0),(5,7,2); stage 2 pairs = (0,4,0),(1,5,1),(2,6,2),(3,7,3); done 19 cycles after start accepted.
REQ-030 Stall held 3 cycles at stage 1, j=1 -> triple (1,3,2) held with valid=0 for 3 cycles, reissued with valid=1, and done delayed by exactly 3 cycles.
REQ-031 rst_n low in stage 2 DRAIN -> all outputs 0 and IDLE at once; the next start replays the full sequence from (0,1,0).
REQ-032 start held high continuously -> back-to-back schedules separated by exactly one IDLE cycle; pulses while busy are ignored.
REQ-033 GAP=0, LOG2N=2 -> valid is continuous for 4 cycles: (0,1,0),(2,3,0),(0,2,0),(1,3,1), then done.
